cva6_pma_region_unit: RTL

- Runtime-programmable physical memory attribute (PMA) checker.
- Generalises the fixed non-idempotent, execute and cached region rule lists into one table of NrRegions entries.
  - Entries are reset from parameters and rewritable through a register port.
  - Each entry has a lock bit.
- Serves NrPorts registered lookups per cycle to the load/store unit and the frontend.
- Pulses a change strobe so the MMU and caches can flush stale attributes.

---
 rtl/cva6_pma_region_unit_pkg.sv | 25 ++
 rtl/cva6_pma_region_unit_if.sv | 46 ++++
 rtl/cva6_pma_match.sv | 53 +++++
 rtl/cva6_pma_region_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cva6_pma_region_unit_pkg.sv
// PMA region unit shared types: attribute bits, table entry, field codes.
// Table entries hold 64-bit base/len so one struct serves any PLEN <= 64.
package config_pkg;

  localparam int PMA_AW = 64;

  typedef struct packed {
    logic l;
    logic n;
    logic x;
    logic c;
  } pma_attr_t;

  typedef struct packed {
    logic [PMA_AW-1:0] base;
    logic [PMA_AW-1:0] len;
    pma_attr_t         attr;
  } pma_region_t;

  localparam logic [1:0] PMA_FIELD_BASE = 2'd0;
  localparam logic [1:0] PMA_FIELD_LEN  = 2'd1;
  localparam logic [1:0] PMA_FIELD_ATTR = 2'd2;
  localparam logic [1:0] PMA_FIELD_RSVD = 2'd3;

endpackage

// File: rtl/cva6_pma_region_unit_if.sv
// PMA region unit bus: config register port plus NrPorts lookup ports.
// master drives requests (cfg_*_i, lk_*_i); slave returns responses (*_o).
interface cva6_pma_region_unit_if #(
  parameter int NrRegions = 8,
  parameter int NrPorts   = 2,
  parameter int PLEN      = 56
);

  localparam int IdxW = (NrRegions > 1) ? $clog2(NrRegions) : 1;

  logic                          cfg_req_i;
  logic                          cfg_we_i;
  logic [IdxW-1:0]               cfg_idx_i;
  logic [1:0]                    cfg_field_i;
  logic [PLEN-1:0]               cfg_wdata_i;
  logic [PLEN-1:0]               cfg_rdata_o;
  logic                          cfg_err_o;
  logic                          cfg_change_o;

  logic [NrPorts-1:0]            lk_valid_i;
  logic [NrPorts-1:0][PLEN-1:0]  lk_addr_i;
  logic [NrPorts-1:0]            lk_valid_o;
  logic [NrPorts-1:0]            lk_hit_o;
  logic [NrPorts-1:0]            lk_cached_o;
  logic [NrPorts-1:0]            lk_exec_o;
  logic [NrPorts-1:0]            lk_nonidem_o;

  modport master (
    output cfg_req_i, cfg_we_i, cfg_idx_i,
    output cfg_field_i, cfg_wdata_i,
    input  cfg_rdata_o, cfg_err_o, cfg_change_o,
    output lk_valid_i, lk_addr_i,
    input  lk_valid_o, lk_hit_o, lk_cached_o,
    input  lk_exec_o, lk_nonidem_o
  );

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_idx_i,
    input  cfg_field_i, cfg_wdata_i,
    output cfg_rdata_o, cfg_err_o, cfg_change_o,
    input  lk_valid_i, lk_addr_i,
    output lk_valid_o, lk_hit_o, lk_cached_o,
    output lk_exec_o, lk_nonidem_o
  );

endinterface

// File: rtl/cva6_pma_match.sv
// Combinational priority matcher: regions table + address in,
// hit/cached/exec/nonidem out (lowest matching index wins).
module cva6_pma_match
  import config_pkg::*;
#(
  parameter int NrRegions = 8,
  parameter int PLEN      = 56
) (
  input  pma_region_t     regions [NrRegions],
  input  logic [PLEN-1:0] addr,
  output logic            hit,
  output logic            cached,
  output logic            exec,
  output logic            nonidem
);

  logic [PMA_AW-1:0]    a;
  logic [NrRegions-1:0] m;
  pma_attr_t            sel;
  logic                 unused_l;

  assign a = PMA_AW'(addr);

  // End is formed one bit wider so a region running past the top of
  // the address space clips instead of wrapping to low addresses.
  always_comb begin
    m = '0;
    for (int r = 0; r < NrRegions; r++) begin
      m[r] = (regions[r].len != '0)
          && ({1'b0, a} >= {1'b0, regions[r].base})
          && ({1'b0, a} < ({1'b0, regions[r].base}
                         + {1'b0, regions[r].len}));
    end
  end

  // Scan high to low so the lowest matching index is the last writer.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int r = NrRegions - 1; r >= 0; r--) begin
      if (m[r]) begin
        hit = 1'b1;
        sel = regions[r].attr;
      end
    end
  end

  assign cached   = sel.c;
  assign exec     = sel.x;
  assign nonidem  = ~hit | sel.n;
  assign unused_l = sel.l;

endmodule

// File: rtl/cva6_pma_region_unit.sv
// Programmable PMA table with lock bits, register config port and
// NrPorts registered lookups; clk_i, rst_i (sync high), bus (slave).
module cva6_pma_region_unit
  import config_pkg::*;
#(
  parameter int NrRegions = 8,
  parameter int NrPorts   = 2,
  parameter int PLEN      = 56,
  parameter logic [NrRegions-1:0][PLEN-1:0] RstBase = '0,
  parameter logic [NrRegions-1:0][PLEN-1:0] RstLen  = '0,
  parameter logic [NrRegions-1:0][3:0]      RstAttr = '0
) (
  input logic clk_i,
  input logic rst_i,
  cva6_pma_region_unit_if.slave bus
);

  localparam int IdxW = (NrRegions > 1) ? $clog2(NrRegions) : 1;

  pma_region_t          tbl [NrRegions];
  pma_region_t          cur;
  logic [NrRegions-1:0] sel;
  logic                 in_range;
  logic                 field_ok;
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 cfg_err;
  logic [PLEN-1:0]      rd_val;
  logic [PMA_AW-1:0]    wdata;
  logic                 unused_hi;

  // Index decode doubles as range check: no hit means idx >= NrRegions.
  always_comb begin
    sel = '0;
    cur = '0;
    for (int r = 0; r < NrRegions; r++) begin
      sel[r] = (bus.cfg_idx_i == IdxW'(r));
      if (sel[r]) cur = tbl[r];
    end
  end

  assign in_range  = |sel;
  assign field_ok  = (bus.cfg_field_i != PMA_FIELD_RSVD);
  assign wr_ok     = bus.cfg_req_i & bus.cfg_we_i
                   & in_range & field_ok & ~cur.attr.l;
  assign rd_ok     = bus.cfg_req_i & ~bus.cfg_we_i
                   & in_range & field_ok;
  assign cfg_err   = bus.cfg_req_i
                   & (bus.cfg_we_i ? ~wr_ok : ~rd_ok);
  assign wdata     = PMA_AW'(bus.cfg_wdata_i);
  assign unused_hi = ^{cur.base, cur.len};

  always_comb begin
    rd_val = '0;
    unique case (bus.cfg_field_i)
      PMA_FIELD_BASE: rd_val = cur.base[PLEN-1:0];
      PMA_FIELD_LEN:  rd_val = cur.len[PLEN-1:0];
      PMA_FIELD_ATTR: rd_val = PLEN'(cur.attr);
      default:        rd_val = '0;
    endcase
  end

  // A locked entry rejects every write, so L can only be cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NrRegions; r++) begin
        tbl[r].base <= PMA_AW'(RstBase[r]);
        tbl[r].len  <= PMA_AW'(RstLen[r]);
        tbl[r].attr <= pma_attr_t'(RstAttr[r]);
      end
    end else if (wr_ok) begin
      for (int r = 0; r < NrRegions; r++) begin
        if (sel[r]) begin
          unique case (bus.cfg_field_i)
            PMA_FIELD_BASE: tbl[r].base <= wdata;
            PMA_FIELD_LEN:  tbl[r].len  <= wdata;
            PMA_FIELD_ATTR:
              tbl[r].attr <= pma_attr_t'(bus.cfg_wdata_i[3:0]);
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.cfg_rdata_o  <= '0;
      bus.cfg_err_o    <= 1'b0;
      bus.cfg_change_o <= 1'b0;
    end else begin
      bus.cfg_rdata_o  <= rd_ok ? rd_val : '0;
      bus.cfg_err_o    <= cfg_err;
      bus.cfg_change_o <= wr_ok;
    end
  end

  logic [NrPorts-1:0] m_hit;
  logic [NrPorts-1:0] m_c;
  logic [NrPorts-1:0] m_x;
  logic [NrPorts-1:0] m_n;

  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    cva6_pma_match #(
      .NrRegions (NrRegions),
      .PLEN      (PLEN)
    ) u_match (
      .regions (tbl),
      .addr    (bus.lk_addr_i[p]),
      .hit     (m_hit[p]),
      .cached  (m_c[p]),
      .exec    (m_x[p]),
      .nonidem (m_n[p])
    );
  end

  // Lookups read the table before this cycle's write lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.lk_valid_o   <= '0;
      bus.lk_hit_o     <= '0;
      bus.lk_cached_o  <= '0;
      bus.lk_exec_o    <= '0;
      bus.lk_nonidem_o <= '0;
    end else begin
      bus.lk_valid_o   <= bus.lk_valid_i;
      bus.lk_hit_o     <= m_hit;
      bus.lk_cached_o  <= m_c;
      bus.lk_exec_o    <= m_x;
      bus.lk_nonidem_o <= m_n;
    end
  end

endmodule
